alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one alu_with_reg datapath between two instruction requesters, e.g. control_logic plus a debug/DMA sequencer.
- Accepts one 8-bit instruction at a time over a valid/ready handshake and drives it onto the ALU inst bus for exactly one cycle.
- Waits the fixed datapath result latency, then returns the captured ALU out/cout to the issuing requester.
- Round-robin arbitration, with an optional lock so one requester can run a multi-instruction register sequence uninterrupted.

Parameters:
- BIT_WIDTH, 4, ALU data width.
- INST_WIDTH, 8, instruction width.
- RESULT_LAT, 1, cycles from the inst-drive cycle to ALU result valid (min 1, max 7).
- LOCK_TIMEOUT, 15, IDLE cycles without an owner request before a held lock is force-released (min 1).
- NOP_INST, 8'h00, instruction driven when not issuing; must encode a non-writing op.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an instruction.
- req0_inst  input  INST_WIDTH  requester 0 instruction.
- req0_lock  input  1  keep/acquire lock after this instruction.
- req0_ready  output  1  requester 0 instruction accepted this cycle when valid.
- rsp0_valid  output  1  one-cycle result pulse for requester 0.
- rsp0_data  output  BIT_WIDTH  result data.
- rsp0_cout  output  1  result carry.
- req1_valid, req1_inst, req1_lock, req1_ready, rsp1_valid, rsp1_data, rsp1_cout: same as requester 0, for requester 1.
- alu_inst  output  INST_WIDTH  to datapath instruction bus.
- alu_out  input  BIT_WIDTH  datapath result.
- alu_cout  input  1  datapath carry.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  1  requester owning the current or last transaction.

Behaviour:
- Reset values: state IDLE; rr pointer 0 (requester 0 preferred); lock clear; timeout counter 0; all ready/rsp_valid 0; rsp data/cout 0; alu_inst = NOP_INST; busy 0; grant_id 0.
- Reset during any state abandons the transaction: no response, NOP_INST on the next cycle.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE: reqN_ready is combinational and high only for the arbitration winner.
  - Winner without a lock: if only one valid, that one. If both valid, the pointer side.
  - Winner with a lock held: only the owner can win; the other requester gets ready 0 even when the owner is idle.
  - On valid&&ready: latch inst, set grant_id, set the pointer to the other requester, go to EXEC.
  - Lock: set owner when req_lock=1, clear when req_lock=0.
- EXEC, 1 cycle: alu_inst = latched inst. Go to WAIT with the wait counter at RESULT_LAT.
- WAIT: alu_inst = NOP_INST. Counter decrements. On the final WAIT cycle, alu_out/alu_cout are registered; then go to RESP.
- RESP, 1 cycle: rsp{grant_id}_valid=1 with the registered data/cout, other rsp_valid=0; then IDLE.
  - The rsp data/cout hold their value until the next capture.
  - No response backpressure.
- Timing: instruction accepted at the edge ending cycle t gives EXEC at t+1 and RESP at t+2+RESULT_LAT, next accept at t+3+RESULT_LAT or later. Peak rate is one instruction per 3+RESULT_LAT cycles.
- Lock timeout:
  - While locked and in IDLE with owner valid=0, the counter increments each cycle.
  - At LOCK_TIMEOUT the lock clears; arbitration is normal from that cycle on, including the cycle the counter hits LOCK_TIMEOUT.
  - The counter resets on any owner accept or lock clear.
- Inputs: ready is never asserted outside IDLE; inputs outside IDLE are ignored (requesters must hold valid/inst stable until ready).
- Widths: rsp data equals alu_out exactly; no arithmetic in this block. grant_id changes only on accept.

Test Plan:
- Reset and single request, RESULT_LAT=1:
  - rst 2 cycles, then req0_valid, inst=8'h2A, lock=0, with alu_out=4'h9, cout=1 at the capture cycle.
  - Required: req0_ready same cycle; alu_inst=8'h2A for exactly 1 cycle, NOP otherwise; rsp0_valid pulse 3 cycles after accept with data 9, cout 1; rsp1_valid never asserted.
- Simultaneous requests:
  - Both valid continuously with 8'h11 and 8'h22.
  - Required: grants alternate 0,1,0,1; alu_inst sequence 11,22,11,22 at 4-cycle spacing; responses land on the matching port.
- Lock sequence: req0 sends 3 instructions with lock=1,1,0 while req1 is valid throughout.
  - Required: all three req0 instructions issue consecutively; req1_ready stays 0 until after the third; req1 is granted next.
- Lock timeout: req0 acquires the lock, then drops valid; req1 is valid.
  - Required: req1_ready stays low for LOCK_TIMEOUT=15 IDLE cycles, then asserts; lock clear.
- Reset mid-operation: assert rst during WAIT with RESULT_LAT=3.
  - Required: no rsp pulse; busy=0 and alu_inst=NOP_INST next cycle; the pointer is back at 0, so both-valid grants requester 0 first.
- Latency sweep: RESULT_LAT=1,2,7.
  - Required: rsp pulse at accept+2+RESULT_LAT, with the captured value equal to alu_out on the final WAIT cycle, not earlier values.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one ALU datapath between two requesters using round-robin arbitration with an optional owner lock.
// Issues one instruction per 3+RESULT_LAT cycles. Ready is only offered in IDLE, and the response pulse cannot be stalled.
module alu_share_arbiter #(
  parameter int                    BIT_WIDTH    = 4,
  parameter int                    INST_WIDTH   = 8,
  parameter int                    RESULT_LAT   = 1,
  parameter int                    LOCK_TIMEOUT = 15,
  parameter logic [INST_WIDTH-1:0] NOP_INST     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [INST_WIDTH-1:0] req0_inst,
  input  logic                  req0_lock,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [BIT_WIDTH-1:0]  rsp0_data,
  output logic                  rsp0_cout,
  input  logic                  req1_valid,
  input  logic [INST_WIDTH-1:0] req1_inst,
  input  logic                  req1_lock,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [BIT_WIDTH-1:0]  rsp1_data,
  output logic                  rsp1_cout,
  output logic [INST_WIDTH-1:0] alu_inst,
  input  logic [BIT_WIDTH-1:0]  alu_out,
  input  logic                  alu_cout,
  output logic                  busy,
  output logic                  grant_id
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_CNT  = TW'(LOCK_TIMEOUT);
  localparam logic [2:0]    LAT_CNT = 3'(RESULT_LAT);

  logic [1:0]            state_q, state_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  grant_q, grant_d;
  logic                  ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic                  owner_q, owner_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [BIT_WIDTH-1:0]  data_q, data_d;
  logic                  cout_q, cout_d;
  logic                  lock_eff, win_vld, win_id;

  // A lock whose timeout count has expired no longer restricts arbitration, starting in that same cycle.
  always_comb begin
    lock_eff = lock_q && (tcnt_q != TO_CNT);
    win_vld  = 1'b0;
    win_id   = 1'b0;
    if (state_q == S_IDLE) begin
      if (lock_eff) begin
        win_id  = owner_q;
        win_vld = owner_q ? req1_valid : req0_valid;
      end else if (req0_valid && req1_valid) begin
        win_vld = 1'b1;
        win_id  = ptr_q;
      end else if (req0_valid || req1_valid) begin
        win_vld = 1'b1;
        win_id  = req1_valid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    tcnt_d  = tcnt_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          inst_d  = win_id ? req1_inst : req0_inst;
          lock_d  = win_id ? req1_lock : req0_lock;
          grant_d = win_id;
          owner_d = win_id;
          ptr_d   = ~win_id;
          tcnt_d  = '0;
          state_d = S_EXEC;
        end else if (lock_q) begin
          if (!lock_eff) begin
            lock_d = 1'b0;
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_EXEC: begin
        wcnt_d  = LAT_CNT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) begin
          data_d  = alu_out;
          cout_d  = alu_cout;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= NOP_INST;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      tcnt_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
    end
  end

  assign req0_ready = win_vld && !win_id;
  assign req1_ready = win_vld && win_id;
  assign alu_inst   = (state_q == S_EXEC) ? inst_q : NOP_INST;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign rsp0_valid = (state_q == S_RESP) && !grant_q;
  assign rsp1_valid = (state_q == S_RESP) && grant_q;
  assign rsp0_data  = data_q;
  assign rsp1_data  = data_q;
  assign rsp0_cout  = cout_q;
  assign rsp1_cout  = cout_q;
endmodule
